// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - IF/DM arbiter for one single-port unified memory with req/ack handshake.
// Tie-break: fixed DM > IF by default; MEM_ARB_RR_EN selects round-robin.
module pipe_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    state_t        state, state_d;
    logic          mem_req_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          if_ready_d, dm_ready_d;
    logic [DW-1:0] if_rdata_d, dm_rdata_d;
    logic          if_elig, dm_elig, pick_dm, pick_if;

`ifdef MEM_ARB_RR_EN
    // 1 = IF was granted last, so DM wins the next tie
    logic          rr_last, rr_last_d;
`endif

    // A requester whose ready pulse is out this cycle has already been served
    assign if_elig = if_req & ~if_ready;
    assign dm_elig = dm_req & ~dm_ready;

`ifdef MEM_ARB_RR_EN
    assign pick_dm = dm_elig & (~if_elig | rr_last);
`else
    assign pick_dm = dm_elig;
`endif
    assign pick_if = if_elig & ~pick_dm;

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            state     <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ready  <= if_ready_d;
            dm_ready  <= dm_ready_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            rr_last   <= rr_last_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
`ifdef MEM_ARB_RR_EN
        rr_last_d   = rr_last;
`endif
        case (state)
            IDLE, RESP: begin
                if (pick_dm) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_RR_EN
                    rr_last_d   = 1'b0;
`endif
                end else if (pick_if) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
                    rr_last_d   = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    // stores complete with zero read data
                    dm_rdata_d = mem_we ? '0 : mem_rdata;
                    dm_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
